// File: rtl/filter_2d_pkg.sv
// filter_2d_pkg: shared types and constants for the 3x3 convolution engine.
// Holds the FSM state enum, datapath widths, default kernel and tap offsets.
package filter_2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TAP,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam int NTAPS  = 9;
    localparam int PROD_W = 17;
    localparam int ACC_W  = 21;

    // Packed arrays: the leftmost element is index 8, the rightmost index 0.
    localparam logic [8:0][7:0] DEF_KERNEL = {
        8'd1, 8'd2, 8'd1,
        8'd2, 8'd4, 8'd2,
        8'd1, 8'd2, 8'd1
    };

    // Two-bit signed offsets: 01 = +1, 00 = 0, 11 = -1.
    localparam logic [8:0][1:0] TAP_DX = {
        2'b01, 2'b00, 2'b11,
        2'b01, 2'b00, 2'b11,
        2'b01, 2'b00, 2'b11
    };

    localparam logic [8:0][1:0] TAP_DY = {
        2'b01, 2'b01, 2'b01,
        2'b00, 2'b00, 2'b00,
        2'b11, 2'b11, 2'b11
    };

endpackage

// File: rtl/filter_2d_if.sv
// filter_2d_if: single-port memory bus (1-cycle read latency).
// Ports: cs, we, addr, din (engine -> memory), dout (memory -> engine).
interface filter_2d_if #(
    parameter int ADDR_W = 17
);
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    logic [7:0]        dout;

    modport master (
        output cs, we, addr, din,
        input  dout
    );

    modport slave (
        input  cs, we, addr, din,
        output dout
    );
endinterface

// File: rtl/filter_2d_mac.sv
// filter_2d_mac: signed MAC with clear/enable plus shift and output stage.
// Ports: clk, rstn (sync, active-high), i_clr, i_en, i_pix, i_coef, o_result.
// Macro FILTER_2D_SAT_EN: clamp result to 0..255, otherwise wrap to 8 bits.
module filter_2d_mac
    import filter_2d_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [7:0]        i_pix,
    input  logic signed [7:0] i_coef,
    output logic [7:0]        o_result
);
    logic signed [PROD_W-1:0] w_pix_s;
    logic signed [PROD_W-1:0] w_coef_s;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_shift;

    // Pixel is unsigned: zero-extend before the signed multiply.
    assign w_pix_s  = PROD_W'($signed({1'b0, i_pix}));
    assign w_coef_s = PROD_W'(i_coef);
    assign w_prod   = w_pix_s * w_coef_s;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    assign w_shift = r_acc >>> SHIFT;

`ifdef FILTER_2D_SAT_EN
    always_comb begin
        o_result = w_shift[7:0];
        if (w_shift[ACC_W-1]) begin
            o_result = 8'd0;
        end else if (w_shift > ACC_W'(255)) begin
            o_result = 8'd255;
        end
    end
`else
    assign o_result = w_shift[7:0];
`endif

endmodule

// File: rtl/filter_2d.sv
// filter_2d: 3x3 convolution over an image in external single-port RAM.
// Ports: clk, rstn (sync, active-high), start, finish, h_write/h_idx/h_data
// (coefficient port), mem (memory bus master). Option: FILTER_2D_SAT_EN.
module filter_2d
    import filter_2d_pkg::*;
#(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int ADDR_W   = 17,
    parameter int OUT_BASE = 65536,
    parameter int SHIFT    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        finish,
    input  logic        h_write,
    input  logic [3:0]  h_idx,
    input  logic [7:0]  h_data,
    filter_2d_if.master mem
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [3:0]        r_t;
    logic [3:0]        r_tap_d;
    logic              r_inb_d;
    logic signed [7:0] r_coef [NTAPS];

    logic       w_last_x;
    logic       w_last_y;
    logic       w_inb;
    logic       w_clr;
    logic       w_en;
    int         w_nx;
    int         w_ny;
    logic [7:0] w_pix;
    logic [7:0] w_result;

    assign w_last_x = (r_x == XW'(IMG_W - 1));
    assign w_last_y = (r_y == YW'(IMG_H - 1));

    always_comb begin
        w_nx  = int'(r_x) + int'($signed(TAP_DX[r_t]));
        w_ny  = int'(r_y) + int'($signed(TAP_DY[r_t]));
        w_inb = (w_nx >= 0) && (w_nx < IMG_W) &&
                (w_ny >= 0) && (w_ny < IMG_H);
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = TAP;
            TAP:     if (r_t == 4'd8) w_next = DRAIN;
            DRAIN:   w_next = WRITE;
            WRITE:   w_next = (w_last_x && w_last_y) ? DONE : TAP;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem.cs   = 1'b0;
        mem.we   = 1'b0;
        mem.addr = '0;
        mem.din  = '0;
        finish   = 1'b0;
        unique case (r_state)
            TAP: begin
                if (w_inb) begin
                    mem.cs   = 1'b1;
                    mem.addr = ADDR_W'(w_ny * IMG_W + w_nx);
                end
            end
            WRITE: begin
                mem.cs   = 1'b1;
                mem.we   = 1'b1;
                mem.addr = ADDR_W'(OUT_BASE + int'(r_y) * IMG_W + int'(r_x));
                mem.din  = w_result;
            end
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

    // Tap t's read data arrives one cycle later; DRAIN adds tap 8.
    assign w_clr = (r_state == TAP) && (r_t == 4'd0);
    assign w_en  = ((r_state == TAP) && (r_t != 4'd0)) || (r_state == DRAIN);
    assign w_pix = r_inb_d ? mem.dout : 8'd0;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_t     <= '0;
            r_tap_d <= '0;
            r_inb_d <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                r_coef[i] <= DEF_KERNEL[i];
            end
        end else begin
            r_state <= w_next;
            r_tap_d <= r_t;
            r_inb_d <= (r_state == TAP) && w_inb;
            unique case (r_state)
                IDLE: begin
                    r_x <= '0;
                    r_y <= '0;
                    r_t <= '0;
                    if (h_write && (h_idx < 4'(NTAPS))) begin
                        r_coef[h_idx] <= h_data;
                    end
                end
                TAP: begin
                    r_t <= (r_t == 4'd8) ? 4'd0 : r_t + 4'd1;
                end
                WRITE: begin
                    if (w_last_x) begin
                        r_x <= '0;
                        r_y <= w_last_y ? '0 : r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    filter_2d_mac #(
        .SHIFT (SHIFT)
    ) u_mac (
        .clk      (clk),
        .rstn     (rstn),
        .i_clr    (w_clr),
        .i_en     (w_en),
        .i_pix    (w_pix),
        .i_coef   (r_coef[r_tap_d]),
        .o_result (w_result)
    );

endmodule

// File: tb/tb_filter_2d.sv
// tb_filter_2d: scoreboard bench for filter_2d on a small 8x6 image.
// Expected writes are queued per frame and popped as the DUT writes.
module tb_filter_2d;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AW = 7;
    localparam int OB = 64;
    localparam int SH = 4;
    localparam int N  = W * H;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       finish;
    logic       h_write;
    logic [3:0] h_idx;
    logic [7:0] h_data;

    filter_2d_if #(.ADDR_W(AW)) bus ();

    filter_2d #(
        .IMG_W    (W),
        .IMG_H    (H),
        .ADDR_W   (AW),
        .OUT_BASE (OB),
        .SHIFT    (SH)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .finish  (finish),
        .h_write (h_write),
        .h_idx   (h_idx),
        .h_data  (h_data),
        .mem     (bus.master)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [1 << AW];

    always @(posedge clk) begin
        if (bus.cs) begin
            if (bus.we) mem[bus.addr] = bus.din;
            else bus.dout <= mem[bus.addr];
        end
    end

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   reads   = 0;
    int   fin_cnt = 0;
    int   coef [9];

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            if (bus.cs && bus.we) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", int'(bus.addr), -1);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_addr", int'(bus.addr), mon_e.addr);
                    check("wr_data", int'(bus.din), mon_e.data);
                end
            end
            if (bus.cs && !bus.we) reads++;
            if (finish) fin_cnt++;
        end
    end

    function automatic int model_px(input int x, input int y);
        int acc = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int nx = x + dx;
                int ny = y + dy;
                if (nx >= 0 && nx < W && ny >= 0 && ny < H)
                    acc += coef[(dy + 1) * 3 + dx + 1] * int'(mem[ny * W + nx]);
            end
        end
        acc = acc >>> SH;
`ifdef FILTER_2D_SAT_EN
        if (acc < 0) acc = 0;
        if (acc > 255) acc = 255;
`else
        acc = acc & 255;
`endif
        return acc;
    endfunction

    function automatic int nbr_count(input int x, input int y);
        int c = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
                    c++;
        return c;
    endfunction

    task automatic push_expected(output int exp_reads);
        exp_t e;
        exp_reads = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                e.addr = OB + y * W + x;
                e.data = model_px(x, y);
                sb.push_back(e);
                exp_reads += nbr_count(x, y);
            end
        end
    endtask

    task automatic run_frame(input bit poke);
        int cyc;
        int exp_reads;
        push_expected(exp_reads);
        reads   = 0;
        fin_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 100) begin
                start   = 1'b1;
                h_write = 1'b1;
                h_idx   = 4'd4;
                h_data  = 8'h00;
            end else begin
                start   = 1'b0;
                h_write = 1'b0;
            end
        end while (!finish && cyc < 2 * 11 * N);
        check("finish_latency", cyc, 11 * N + 1);
        repeat (3) @(negedge clk);
        check("finish_pulses", fin_cnt, 1);
        check("sb_empty", sb.size(), 0);
        check("read_count", reads, exp_reads);
        sb.delete();
    endtask

    task automatic prog(input int idx, input int val);
        @(negedge clk);
        h_write = 1'b1;
        h_idx   = 4'(idx);
        h_data  = 8'(val);
        @(negedge clk);
        h_write = 1'b0;
        if (idx < 9) coef[idx] = int'($signed(8'(val)));
    endtask

    task automatic set_default();
        coef = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < N; i++) mem[i] = 8'(v);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int dummy;
        rstn    = 1'b1;
        start   = 1'b0;
        h_write = 1'b0;
        h_idx   = '0;
        h_data  = '0;
        set_default();
        repeat (3) @(negedge clk);
        check("rst_cs", int'(bus.cs), 0);
        check("rst_we", int'(bus.we), 0);
        check("rst_addr", int'(bus.addr), 0);
        check("rst_din", int'(bus.din), 0);
        check("rst_finish", int'(finish), 0);
        rstn = 1'b0;

        fill_const(100);
        run_frame(1'b0);
        check("const_corner", int'(mem[OB]), 56);
        check("const_edge", int'(mem[OB + 3 * W]), 75);
        check("const_interior", int'(mem[OB + 3 * W + 3]), 100);

        fill_const(0);
        mem[3 * W + 4] = 8'd255;
        run_frame(1'b0);
        check("imp_centre", int'(mem[OB + 3 * W + 4]), 63);
        check("imp_left", int'(mem[OB + 3 * W + 3]), 31);
        check("imp_diag", int'(mem[OB + 2 * W + 3]), 15);

        for (int i = 0; i < 9; i++) prog(i, (i == 4) ? 16 : 0);
        prog(12, 8'h55);
        fill_rand();
        run_frame(1'b0);
        check("ident_px", int'(mem[OB + 2 * W + 2]), int'(mem[2 * W + 2]));

        prog(4, 127);
        fill_const(255);
        run_frame(1'b0);
`ifdef FILTER_2D_SAT_EN
        check("gain127", int'(mem[OB + 3 * W + 3]), 255);
`else
        check("gain127", int'(mem[OB + 3 * W + 3]), 232);
`endif

        prog(4, 8'hF0);
        run_frame(1'b0);
`ifdef FILTER_2D_SAT_EN
        check("gain_neg", int'(mem[OB + 3 * W + 3]), 0);
`else
        check("gain_neg", int'(mem[OB + 3 * W + 3]), 1);
`endif

        fill_rand();
        push_expected(dummy);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20 * 11 + 2) @(negedge clk);
        check("abort_written", N - sb.size(), 20);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs", int'(bus.cs), 0);
        check("abort_finish", int'(finish), 0);
        check("abort_addr", int'(bus.addr), 0);
        @(negedge clk);
        rstn = 1'b0;
        sb.delete();
        set_default();

        fill_rand();
        run_frame(1'b0);

        fill_rand();
        run_frame(1'b1);

        fill_const(100);
        run_frame(1'b0);
        check("coef_kept", int'(mem[OB + 3 * W + 3]), 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
